// File: rtl/zwait_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | zwait_pkg                                                            |
// | Shared FSM encodings, request indices and the priority picker.       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package zwait_pkg;

    localparam int unsigned c_num_waits = 7;

    localparam logic [2:0] REQ_GLUCLOCK = 3'd0;
    localparam logic [2:0] REQ_COMPORT  = 3'd1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    // Lowest set index wins: gluclock, then comport, then the rest.
    function automatic logic [2:0] lowest_index(input logic [c_num_waits-1:0] bits);
        logic [2:0] v_idx;
        v_idx = 3'd0;
        for (int i = c_num_waits - 1; i >= 0; i--) begin
            if (bits[i]) begin
                v_idx = 3'(i);
            end
        end
        return v_idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/zwait_server_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | zwait_server_if                                                      |
// | Wait-request / AVR service bus between wait generator and server.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface zwait_server_if;

    logic [zwait_pkg::c_num_waits-1:0] waits;
    logic                              avr_done;
    logic                              clr_flags;
    logic                              wait_end;
    logic                              req_valid;
    logic [2:0]                        req_id;
    logic                              timeout_flag;
    logic [7:0]                        svc_count;

    modport master (
        output waits, avr_done, clr_flags,
        input  wait_end, req_valid, req_id, timeout_flag, svc_count
    );

    modport slave (
        input  waits, avr_done, clr_flags,
        output wait_end, req_valid, req_id, timeout_flag, svc_count
    );

endinterface
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_2ff                                                             |
// | Two-flop synchronizer for independent asynchronous level bits.       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic [WIDTH-1:0] i_d,
    output logic      [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/zwait_server.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | zwait_server                                                         |
// | Arbitrates Z80 wait requests to the AVR and pulses wait_end.         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module zwait_server
    import zwait_pkg::*;
#(
    parameter int TIMEOUT_W = 16,
    parameter int END_PULSE = 3
) (
    input  wire logic     fclk,
    input  wire logic     rst,
    zwait_server_if.slave bus
);

    localparam int                   PULSE_W      = $clog2(END_PULSE);
    localparam logic [TIMEOUT_W-1:0] c_timer_one  = TIMEOUT_W'(1);
    localparam logic [TIMEOUT_W-1:0] c_timer_last = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
    localparam logic [PULSE_W-1:0]   c_pulse_one  = PULSE_W'(1);
    localparam logic [PULSE_W-1:0]   c_pulse_last = PULSE_W'(END_PULSE - 1);

    logic [c_num_waits-1:0] w_wsync;
    logic [7:0]             w_wsync_ext;
    logic                   w_any;
    logic                   w_req_clear;
    logic                   w_expire;
    logic                   w_set_timeout;
    state_t                 w_state_next;

    state_t                 r_state;
    logic [2:0]             r_req_id;
    logic [TIMEOUT_W-1:0]   r_timer;
    logic [PULSE_W-1:0]     r_pulse;
    logic                   r_wait_end;
    logic                   r_req_valid;
    logic                   r_timeout_flag;
    logic [7:0]             r_svc_count;

    sync_2ff #(
        .WIDTH (int'(c_num_waits))
    ) u_sync (
        .clk (fclk),
        .rst (rst),
        .i_d (bus.waits),
        .o_q (w_wsync)
    );

    // Padded to 8 bits so every req_id value indexes a real bit.
    assign w_wsync_ext   = {1'b0, w_wsync};
    assign w_any         = |w_wsync;
    assign w_req_clear   = ~w_wsync_ext[r_req_id];
    assign w_expire      = (r_state == GRANT) && (r_timer == c_timer_last);
    assign w_set_timeout = w_expire && !bus.avr_done;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_any)                        w_state_next = GRANT;
            GRANT:   if (bus.avr_done || w_expire)     w_state_next = RELEASE;
            RELEASE: if (r_pulse == c_pulse_last)      w_state_next = DRAIN;
            DRAIN:   if (w_req_clear)                  w_state_next = IDLE;
            default:                                   w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_req_id       <= 3'd0;
            r_timer        <= '0;
            r_pulse        <= '0;
            r_wait_end     <= 1'b0;
            r_req_valid    <= 1'b0;
            r_timeout_flag <= 1'b0;
            r_svc_count    <= 8'd0;
        end else begin
            r_state <= w_state_next;
            if (r_state == IDLE && w_any) begin
                r_req_id <= lowest_index(w_wsync);
            end
            r_timer <= (r_state == GRANT)   ? r_timer + c_timer_one : '0;
            r_pulse <= (r_state == RELEASE) ? r_pulse + c_pulse_one : '0;
            // Registered decode keeps wait_end glitch-free for the async clear it drives.
            r_wait_end  <= (w_state_next == RELEASE);
            r_req_valid <= (w_state_next == GRANT);
            if (r_state == GRANT && w_state_next == RELEASE) begin
                r_svc_count <= r_svc_count + 8'd1;
            end
            if (w_set_timeout) begin
                r_timeout_flag <= 1'b1;
            end else if (bus.clr_flags) begin
                r_timeout_flag <= 1'b0;
            end
        end
    end

    assign bus.wait_end     = r_wait_end;
    assign bus.req_valid    = r_req_valid;
    assign bus.req_id       = r_req_id;
    assign bus.timeout_flag = r_timeout_flag;
    assign bus.svc_count    = r_svc_count;

endmodule
`default_nettype wire

// File: doc/zwait_server.md
ZWAIT_SERVER -- requirements
Module: zwait_server

Interface
- REQ-001 SHALL have parameter TIMEOUT_W, default 16: width of the grant timeout counter.
- REQ-002 SHALL have parameter END_PULSE, default 3: wait_end pulse width in fclk cycles, minimum 2.
- REQ-003 fclk  input  1  sole clock; all state changes on the rising edge.
- REQ-004 rst  input  1  reset, asynchronous, active-high.
- REQ-005 waits  input  7  pending Z80 wait-request bits from the wait generator; asynchronous to fclk.
- REQ-006 avr_done  input  1  one-cycle strobe from the SPI command decoder: AVR has serviced the granted request.
- REQ-007 clr_flags  input  1  one-cycle strobe: clears timeout_flag.
- REQ-008 wait_end  output  1  release pulse to the wait generator, active-high.
- REQ-009 req_valid  output  1  a request is granted and awaits the AVR.
- REQ-010 req_id  output  3  index of the granted waits bit.
- REQ-011 timeout_flag  output  1  sticky: a grant was released by timeout.
- REQ-012 svc_count  output  8  count of completed releases, by either AVR or timeout.

Function
- REQ-013 waits SHALL pass through a two-flop synchronizer before any use (wsync); latency 2 fclk.
- REQ-014 FSM states SHALL be IDLE, GRANT, RELEASE, DRAIN.
- REQ-015 IDLE: if wsync != 0, SHALL latch req_id = lowest set index, then go to GRANT next cycle.
- REQ-016 Priority is fixed: bit0 (gluclock) over bit1 (comport) over bits 6:2.
- REQ-017 GRANT: req_valid=1 and req_id held stable; timeout counter cleared on entry, incremented each cycle.
- REQ-018 GRANT + avr_done=1 SHALL go to RELEASE.
- REQ-019 GRANT + counter reaching all-ones SHALL go to RELEASE and set timeout_flag.
- REQ-020 If avr_done and timeout expiry coincide, avr_done wins and timeout_flag is not set.
- REQ-021 RELEASE: wait_end=1 for exactly END_PULSE cycles, req_valid=0; svc_count +1 (mod 256, wraps 255->0) on entry.
- REQ-022 DRAIN: wait_end=0; SHALL wait until wsync[req_id]=0, then go to IDLE, so that stale synchronized bits cannot trigger a re-grant.
- REQ-023 A request still pending in other bits after DRAIN SHALL be granted from IDLE on the following cycle, with no lost request.
- REQ-024 avr_done outside GRANT SHALL be ignored.
- REQ-025 A waits bit that drops while in GRANT (e.g. Z80 reset) SHALL NOT abort the grant; the release proceeds normally.
- REQ-026 clr_flags SHALL clear timeout_flag next cycle; set and clear in the same cycle results in set.
- REQ-027 wait_end SHALL be driven from a flop, glitch-free, since it feeds an asynchronous clear.

Reset
- REQ-028 rst asserted SHALL immediately force: state IDLE, wait_end=0, req_valid=0, req_id=0, timeout_flag=0, svc_count=0, synchronizer flops 0, timeout counter 0.
- REQ-029 Reset mid-GRANT or mid-RELEASE SHALL abort without a further wait_end pulse; the wait generator is cleared by its own reset.

Structure
- REQ-030 Shared package zwait_pkg SHALL hold the FSM state encodings and the constants REQ_GLUCLOCK=0 and REQ_COMPORT=1.
- REQ-031 The two-flop synchronizer SHALL be the sub-module sync_2ff, instantiated 7 bits wide; the remainder is flat.

Verification
- REQ-032 waits=7'b0000001, avr_done 5 cycles after req_valid rises -> req_id=0, wait_end high 3 cycles, svc_count=1, timeout_flag=0.
- REQ-033 waits=7'b0000011 simultaneously, bit cleared on wait_end -> first grant req_id=0, second grant req_id=1, svc_count=2.
- REQ-034 TIMEOUT_W=4, no avr_done -> release 15 cycles after entering GRANT, timeout_flag=1; clr_flags -> 0.
- REQ-035 avr_done on the expiry cycle (TIMEOUT_W=4) -> release, timeout_flag stays 0.
- REQ-036 rst asserted during RELEASE -> wait_end=0 asynchronously, all outputs at reset values; 256 services -> svc_count wraps to 0.
